// File: rtl/bram_arb_pkg.sv
// Shared types for the two-port BRAM1BE round-robin arbiter.
package bram_arb_pkg;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_A};

    // Read latency of the attached BRAM, in cycles from acceptance to DO.
    function automatic int unsigned rd_latency(input int unsigned pipelined);
        return 32'd1 + pipelined;
    endfunction

endpackage

// File: rtl/bram_arb_tag_pipe.sv
// Fixed-depth shift register of access tags, tracking in-flight BRAM accesses.
module bram_arb_tag_pipe
    import bram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '{default: TAG_IDLE};
        end else begin
            pipe_q[0] <= tag_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/bram1be_rr_arbiter.sv
// Round-robin arbiter between requesters A and B for one single-port byte-enable BRAM,
// with a tag pipeline that routes each BRAM_DO word back to the port that issued it.
module bram1be_rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned PIPELINED  = 0,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CHUNKSIZE  = 8,
    parameter int unsigned WE_WIDTH   = 4
) (
    input  logic                  CLK,
    input  logic                  RST,

    input  logic                  A_VALID,
    output logic                  A_RDY,
    input  logic [WE_WIDTH-1:0]   A_WE,
    input  logic [ADDR_WIDTH-1:0] A_ADDR,
    input  logic [DATA_WIDTH-1:0] A_DI,
    output logic                  A_RVALID,
    output logic [DATA_WIDTH-1:0] A_RDATA,

    input  logic                  B_VALID,
    output logic                  B_RDY,
    input  logic [WE_WIDTH-1:0]   B_WE,
    input  logic [ADDR_WIDTH-1:0] B_ADDR,
    input  logic [DATA_WIDTH-1:0] B_DI,
    output logic                  B_RVALID,
    output logic [DATA_WIDTH-1:0] B_RDATA,

    output logic                  BRAM_EN,
    output logic [WE_WIDTH-1:0]   BRAM_WE,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
    output logic [DATA_WIDTH-1:0] BRAM_DI,
    input  logic [DATA_WIDTH-1:0] BRAM_DO
);

    localparam int unsigned LAT = rd_latency(PIPELINED);

    if (DATA_WIDTH != WE_WIDTH * CHUNKSIZE) begin : g_bad_cfg
        $error("DATA_WIDTH must equal WE_WIDTH*CHUNKSIZE");
    end

    logic pri_q;
    logic pri_d;
    logic a_gnt_c;
    logic b_gnt_c;
    tag_t tag_in;
    tag_t tag_out;

    // Grant: a lone requester wins; under contention the favoured side (pri_q) wins.
    always_comb begin
        a_gnt_c = 1'b0;
        b_gnt_c = 1'b0;
        pri_d   = pri_q;
        if (!RST) begin
            if (A_VALID && (!B_VALID || (pri_q == 1'b0))) begin
                a_gnt_c = 1'b1;
            end else if (B_VALID) begin
                b_gnt_c = 1'b1;
            end
            // Favour the loser next time, only when both were contending.
            if (A_VALID && B_VALID) begin
                pri_d = a_gnt_c;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pri_q <= 1'b0;
        end else begin
            pri_q <= pri_d;
        end
    end

    assign A_RDY     = a_gnt_c;
    assign B_RDY     = b_gnt_c;
    assign BRAM_EN   = a_gnt_c | b_gnt_c;
    assign BRAM_WE   = b_gnt_c ? B_WE : (a_gnt_c ? A_WE : '0);
    assign BRAM_ADDR = b_gnt_c ? B_ADDR : A_ADDR;
    assign BRAM_DI   = b_gnt_c ? B_DI : A_DI;

    assign tag_in.valid = a_gnt_c | b_gnt_c;
    assign tag_in.owner = b_gnt_c ? OWN_B : OWN_A;

    bram_arb_tag_pipe #(
        .DEPTH (LAT)
    ) u_tag_pipe (
        .clk   (CLK),
        .rst   (RST),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    // Responses are masked during reset so stale in-flight tags never surface.
    assign A_RVALID = !RST && tag_out.valid && (tag_out.owner == OWN_A);
    assign B_RVALID = !RST && tag_out.valid && (tag_out.owner == OWN_B);
    assign A_RDATA  = BRAM_DO;
    assign B_RDATA  = BRAM_DO;

endmodule

// File: tb/tb_bram1be_rr_arbiter.sv
// Directed bench: drives identical traffic into a PIPELINED=0 and a PIPELINED=1 arbiter,
// each with its own write-first byte-enable BRAM model, and checks grants and responses.
module tb_bram1be_rr_arbiter;

    logic        clk;
    logic        rst;
    logic        a_v, b_v;
    logic [3:0]  a_we, b_we;
    logic [9:0]  a_addr, b_addr;
    logic [31:0] a_di, b_di;
    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [31:0] pl_data;

    logic [1:0]        a_rdy, b_rdy, a_rvalid, b_rvalid, bram_en;
    logic [1:0][31:0]  a_rdata, b_rdata, bram_di, bram_do;
    logic [1:0][3:0]   bram_we;
    logic [1:0][9:0]   bram_addr;

    int n_chk;
    int n_fail;
    int cyc_n;

    // Expected response schedule per instance, indexed by cycle modulo 8.
    logic        sch_a [2][8];
    logic        sch_b [2][8];
    logic [31:0] sch_d [2][8];

    logic [9:0]  pre_addr [5] = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd5};
    logic [31:0] pre_data [5] = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002,
                                  32'h0000_0000, 32'h1122_3344};
    logic [31:0] exp5 [4]     = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002,
                                  32'h00BB_00DD};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar p = 0; p < 2; p++) begin : g_inst
        logic [31:0] mem [1024];
        logic [31:0] merged;
        logic [31:0] do1;
        logic [31:0] do2;

        always_comb begin
            merged = mem[bram_addr[p]];
            for (int k = 0; k < 4; k++) begin
                if (bram_we[p][k]) merged[k*8 +: 8] = bram_di[p][k*8 +: 8];
            end
        end

        always @(posedge clk) begin
            if (pl_en) begin
                mem[pl_addr] <= pl_data;
            end else if (bram_en[p]) begin
                mem[bram_addr[p]] <= merged;
                do1 <= merged;
            end
            do2 <= do1;
        end

        assign bram_do[p] = (p == 1) ? do2 : do1;

        bram1be_rr_arbiter #(
            .PIPELINED  (p),
            .ADDR_WIDTH (10),
            .DATA_WIDTH (32),
            .CHUNKSIZE  (8),
            .WE_WIDTH   (4)
        ) u_dut (
            .CLK       (clk),
            .RST       (rst),
            .A_VALID   (a_v),
            .A_RDY     (a_rdy[p]),
            .A_WE      (a_we),
            .A_ADDR    (a_addr),
            .A_DI      (a_di),
            .A_RVALID  (a_rvalid[p]),
            .A_RDATA   (a_rdata[p]),
            .B_VALID   (b_v),
            .B_RDY     (b_rdy[p]),
            .B_WE      (b_we),
            .B_ADDR    (b_addr),
            .B_DI      (b_di),
            .B_RVALID  (b_rvalid[p]),
            .B_RDATA   (b_rdata[p]),
            .BRAM_EN   (bram_en[p]),
            .BRAM_WE   (bram_we[p]),
            .BRAM_ADDR (bram_addr[p]),
            .BRAM_DI   (bram_di[p]),
            .BRAM_DO   (bram_do[p])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc_n, got, exp);
        end
    endtask

    // One cycle: g = expected grant (0 none, 1 A, 2 B), ed = expected response data.
    task automatic step(input int g, input logic [31:0] ed);
        int s;
        #1;
        if (rst) begin
            for (int p = 0; p < 2; p++)
                for (int k = 0; k < 8; k++) begin
                    sch_a[p][k] = 1'b0;
                    sch_b[p][k] = 1'b0;
                end
        end
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("a_rdy[%0d]", p), 32'(a_rdy[p]), 32'(g == 1));
            chk($sformatf("b_rdy[%0d]", p), 32'(b_rdy[p]), 32'(g == 2));
            chk($sformatf("bram_en[%0d]", p), 32'(bram_en[p]), 32'(g != 0));
            if (g == 0) begin
                chk($sformatf("bram_we_idle[%0d]", p), 32'(bram_we[p]), 32'd0);
            end else begin
                chk($sformatf("bram_we[%0d]", p), 32'(bram_we[p]), 32'((g == 1) ? a_we : b_we));
                chk($sformatf("bram_addr[%0d]", p), 32'(bram_addr[p]),
                    32'((g == 1) ? a_addr : b_addr));
                chk($sformatf("bram_di[%0d]", p), bram_di[p], (g == 1) ? a_di : b_di);
                s = (cyc_n + p + 1) % 8;
                if (g == 1) sch_a[p][s] = 1'b1;
                else        sch_b[p][s] = 1'b1;
                sch_d[p][s] = ed;
            end
        end
        @(negedge clk);
        s = cyc_n % 8;
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("a_rvalid[%0d]", p), 32'(a_rvalid[p]), 32'(sch_a[p][s]));
            chk($sformatf("b_rvalid[%0d]", p), 32'(b_rvalid[p]), 32'(sch_b[p][s]));
            if (sch_a[p][s]) chk($sformatf("a_rdata[%0d]", p), a_rdata[p], sch_d[p][s]);
            if (sch_b[p][s]) chk($sformatf("b_rdata[%0d]", p), b_rdata[p], sch_d[p][s]);
            sch_a[p][s] = 1'b0;
            sch_b[p][s] = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc_n = 0;
        rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        a_v = 1'b0; a_we = '0; a_addr = '0; a_di = '0;
        b_v = 1'b0; b_we = '0; b_addr = '0; b_di = '0;
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 8; k++) begin
                sch_a[p][k] = 1'b0;
                sch_b[p][k] = 1'b0;
                sch_d[p][k] = '0;
            end
        @(posedge clk);
        #1;

        // Reset with both requesters valid; preload the BRAMs meanwhile.
        a_v = 1'b1; b_v = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pl_en = 1'b1; pl_addr = pre_addr[i]; pl_data = pre_data[i];
            step(0, 32'd0);
        end
        pl_en = 1'b0; a_v = 1'b0; b_v = 1'b0;
        rst = 1'b0;

        // Single read from A in the first cycle out of reset.
        a_v = 1'b1; a_addr = 10'd5;
        step(1, 32'h1122_3344);
        a_v = 1'b0;
        step(0, 32'd0); step(0, 32'd0);

        // Byte-masked write from B, then A reads the same word next cycle.
        b_v = 1'b1; b_we = 4'b0101; b_addr = 10'd3; b_di = 32'hAABB_CCDD;
        step(2, 32'h00BB_00DD);
        b_v = 1'b0; b_we = 4'b0000;
        a_v = 1'b1; a_addr = 10'd3;
        step(1, 32'h00BB_00DD);
        a_v = 1'b0;
        step(0, 32'd0); step(0, 32'd0);

        // Continuous contention alternates A,B,A,B...
        a_v = 1'b1; a_addr = 10'd5; b_v = 1'b1; b_addr = 10'd0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) step(1, 32'h1122_3344);
            else            step(2, 32'h1000_0000);
        end
        a_v = 1'b0; b_v = 1'b0;
        step(0, 32'd0); step(0, 32'd0);

        // B alone three times leaves priority with A.
        b_v = 1'b1; b_addr = 10'd1;
        for (int i = 0; i < 3; i++) step(2, 32'h1000_0001);
        a_v = 1'b1; a_addr = 10'd2;
        step(1, 32'h1000_0002);
        step(2, 32'h1000_0001);
        a_v = 1'b0; b_v = 1'b0;
        step(0, 32'd0); step(0, 32'd0);

        // Back-to-back reads at addresses 0..3.
        a_v = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_addr = 10'(i);
            step(1, exp5[i]);
        end
        a_v = 1'b0;
        step(0, 32'd0); step(0, 32'd0);

        // Two reads in flight, then reset: responses dropped, priority back to A.
        a_v = 1'b1; a_addr = 10'd0; b_v = 1'b1; b_addr = 10'd1;
        step(1, 32'h1000_0000);
        b_v = 1'b0; a_addr = 10'd1;
        step(1, 32'h1000_0001);
        rst = 1'b1; b_v = 1'b1;
        step(0, 32'd0);
        rst = 1'b0; a_addr = 10'd2; b_addr = 10'd0;
        step(1, 32'h1000_0002);
        a_v = 1'b0; b_v = 1'b0;
        step(0, 32'd0); step(0, 32'd0); step(0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
